// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter giving two requesters one shared byte-wide flash reader.
// Each requester keeps the enable/ready handshake, and a stalled read times out.
module flash_read_arbiter #(
    parameter int          ADDR_W       = 11,
    parameter int unsigned TIMEOUT      = 4096,
    parameter logic [7:0]  TIMEOUT_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_en,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic [7:0]        req0_data,
    input  logic              req1_en,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic [7:0]        req1_data,
    output logic              flash_en,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic              flash_ready,
    input  logic [7:0]        flash_data,
    output logic              timeout_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, HOLD} state_t;

    state_t            state, state_next;
    logic              grant, grant_d;
    logic              last_grant, last_grant_d;
    logic              aborted, aborted_d;
    logic [TW-1:0]     tcount, tcount_d;
    logic [1:0]        served, served_d;
    logic [1:0]        en, deliver, ready_d;
    logic [7:0]        dbyte, data0_d, data1_d;
    logic              flash_en_d, timeout_err_d;
    logic [ADDR_W-1:0] flash_addr_d;
    logic              gnt_en, pick, complete, expire;

    assign en       = {req1_en, req0_en};
    assign gnt_en   = grant ? req1_en : req0_en;
    assign pick     = (req0_en && req1_en) ? ~last_grant : req1_en;
    assign complete = (state == WAIT_DONE) && flash_ready;
    assign expire   = (TIMEOUT != 0) && ((state == WAIT_START) || (state == WAIT_DONE))
                      && (tcount == TLAST) && !complete;

    always_ff @(posedge clk) begin : state_register
        if (reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            aborted     <= 1'b0;
            tcount      <= '0;
            served      <= '0;
            flash_en    <= 1'b0;
            flash_addr  <= '0;
            req0_ready  <= 1'b1;
            req1_ready  <= 1'b1;
            req0_data   <= '0;
            req1_data   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            grant       <= grant_d;
            last_grant  <= last_grant_d;
            aborted     <= aborted_d;
            tcount      <= tcount_d;
            served      <= served_d;
            flash_en    <= flash_en_d;
            flash_addr  <= flash_addr_d;
            req0_ready  <= ready_d[0];
            req1_ready  <= ready_d[1];
            req0_data   <= data0_d;
            req1_data   <= data1_d;
            timeout_err <= timeout_err_d;
        end
    end

    always_comb begin : next_state_logic
        state_next = state;
        unique case (state)
            IDLE:       if (req0_en || req1_en) state_next = WAIT_START;
            WAIT_START: if (expire) state_next = HOLD;
                        else if (!flash_ready) state_next = WAIT_DONE;
            WAIT_DONE:  if (complete || expire) state_next = HOLD;
            // an aborted or timed-out read may still be busy downstream
            HOLD:       if (flash_ready && (aborted || !gnt_en)) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin : output_logic
        flash_en_d    = flash_en;
        flash_addr_d  = flash_addr;
        grant_d       = grant;
        last_grant_d  = last_grant;
        aborted_d     = aborted;
        tcount_d      = tcount;
        timeout_err_d = timeout_err;
        deliver       = '0;
        dbyte         = flash_data;
        unique case (state)
            IDLE: begin
                if (req0_en || req1_en) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    flash_addr_d = pick ? req1_addr : req0_addr;
                    flash_en_d   = 1'b1;
                    tcount_d     = '0;
                    aborted_d    = 1'b0;
                end
            end
            WAIT_START, WAIT_DONE: begin
                if (TIMEOUT != 0) tcount_d = tcount + TW'(1);
                if (!gnt_en) aborted_d = 1'b1;
                if (complete || expire) begin
                    flash_en_d     = 1'b0;
                    deliver[grant] = gnt_en && !aborted;
                end
                if (expire) begin
                    timeout_err_d = 1'b1;
                    dbyte         = TIMEOUT_BYTE;
                end
            end
            default: ;
        endcase
        // served keeps ready high after delivery until the requester lets go
        served_d = en & (deliver | served);
        ready_d  = ~en | deliver | served;
        data0_d  = deliver[0] ? dbyte : req0_data;
        data1_d  = deliver[1] ? dbyte : req1_data;
    end

endmodule
